bmem_burst_responder: RTL and testbench

BMEM_BURST_RESPONDER -- requirements
Module: bmem_burst_responder

---
 rtl/bmem_pkg.sv | 22 ++
 rtl/bmem_req_fifo.sv | 48 ++++
 rtl/bmem_burst_responder.sv | 161 ++++++++++++++++
 tb/tb_bmem_burst_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_pkg.sv
// bmem_pkg: shared beat/line widths and state types for the
// burst responder and its request FIFO.
package bmem_pkg;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_W1,
        WR_W2,
        WR_W3
    } wr_state_t;

    typedef logic [$clog2(BEATS)-1:0] beat_idx_t;
endpackage

// File: rtl/bmem_req_fifo.sv
// bmem_req_fifo: DEPTH x W read-request queue with push/pop/full/empty.
module bmem_req_fifo
    import bmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/bmem_burst_responder.sv
// bmem_burst_responder: 256-bit line store serving 4-beat read bursts.
// Define BMEM_RESP_PROTOCOL_CHECK_EN to drive the sticky proto_err flag.
module bmem_burst_responder
    import bmem_pkg::*;
#(
    parameter int DEPTH_LINES  = 256,
    parameter int READ_LATENCY = 4,
    parameter int RQ_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [31:0] bmem_addr,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic        bmem_rvalid,
    output logic [63:0] bmem_rdata,
    output logic [31:0] bmem_raddr,
    output logic        proto_err
);
    localparam int IW = $clog2(DEPTH_LINES);
    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    logic [LINE_W-1:0]        mem [DEPTH_LINES];
    logic [LINE_W-1:0]        line_q;
    logic [LINE_W-BEAT_W-1:0] wbuf;
    logic [IW-1:0]            wr_idx;
    wr_state_t                wr_state;
    rd_state_t                rd_state;
    beat_idx_t                beat;
    logic [3:0]               cnt;

    logic          rd_acc;
    logic          wr_start;
    logic          pend;
    logic          pop;
    logic          launch;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   head;
    logic [31:0]   src_addr;
    logic [IW-1:0] src_idx;

    assign bmem_ready = (wr_state == WR_IDLE) && !fifo_full;
    assign wr_start   = bmem_write && bmem_ready;
    assign rd_acc     = bmem_read && bmem_ready && !bmem_write;
    assign pend       = rd_acc || !fifo_empty;
    assign pop        = (rd_state == RD_BURST) && (beat == 2'd2);
    // An entry stays queued until its last beat goes out; an empty
    // queue at launch means the request is being accepted right now.
    assign src_addr   = fifo_empty ? bmem_addr : head;
    assign src_idx    = src_addr[5 +: IW];

    bmem_req_fifo #(
        .DEPTH(RQ_DEPTH),
        .W    (32)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rd_acc),
        .pop  (pop),
        .din  (bmem_addr),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= WR_IDLE;
        end else begin
            unique case (wr_state)
                WR_IDLE: if (wr_start) begin
                    wr_state        <= WR_W1;
                    wr_idx          <= bmem_addr[5 +: IW];
                    wbuf[0 +: 64]   <= bmem_wdata;
                end
                WR_W1: if (bmem_write) begin
                    wr_state        <= WR_W2;
                    wbuf[64 +: 64]  <= bmem_wdata;
                end else wr_state <= WR_IDLE;
                WR_W2: if (bmem_write) begin
                    wr_state        <= WR_W3;
                    wbuf[128 +: 64] <= bmem_wdata;
                end else wr_state <= WR_IDLE;
                WR_W3: wr_state <= WR_IDLE;
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_state == WR_W3 && bmem_write)
            mem[wr_idx] <= {bmem_wdata, wbuf};
    end

    always_comb begin
        launch = 1'b0;
        unique case (rd_state)
            RD_IDLE:  launch = pend && (READ_LATENCY == 1);
            RD_WAIT:  launch = (cnt == 4'd1);
            RD_BURST: launch = (beat == 2'd3) && pend && (READ_LATENCY == 1);
            default:  launch = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state    <= RD_IDLE;
            cnt         <= '0;
            beat        <= '0;
            bmem_rvalid <= 1'b0;
            bmem_rdata  <= '0;
            bmem_raddr  <= '0;
        end else begin
            bmem_rvalid <= 1'b0;
            bmem_rdata  <= '0;
            if (launch) begin
                rd_state    <= RD_BURST;
                beat        <= '0;
                line_q      <= mem[src_idx];
                bmem_rvalid <= 1'b1;
                bmem_rdata  <= mem[src_idx][BEAT_W-1:0];
                bmem_raddr  <= src_addr & 32'hffff_ffe0;
            end else begin
                unique case (rd_state)
                    RD_IDLE: if (pend) begin
                        rd_state <= RD_WAIT;
                        cnt      <= LAT_M1;
                    end
                    RD_WAIT: cnt <= cnt - 4'd1;
                    RD_BURST: if (beat == 2'd3) begin
                        rd_state <= pend ? RD_WAIT : RD_IDLE;
                        cnt      <= LAT_M1;
                    end else begin
                        beat        <= beat + 2'd1;
                        bmem_rvalid <= 1'b1;
                        bmem_rdata  <= line_q[BEAT_W * (int'(beat) + 1) +: BEAT_W];
                    end
                    default: rd_state <= RD_IDLE;
                endcase
            end
        end
    end

`ifdef BMEM_RESP_PROTOCOL_CHECK_EN
    logic err_ev;

    assign err_ev = (bmem_read && !rd_acc)
                 || (bmem_write && !bmem_ready && wr_state == WR_IDLE)
                 || (wr_state != WR_IDLE && !bmem_write);

    always_ff @(posedge clk) begin
        if (rst) proto_err <= 1'b0;
        else if (err_ev) proto_err <= 1'b1;
    end
`else
    assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_bmem_burst_responder.sv
// Scoreboarded bench for bmem_burst_responder: reads checked against a
// line model, plus latency, queueing, wrap, error and reset scenarios.
module tb_bmem_burst_responder;
    localparam int LAT = 4;
    localparam int RQ  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bmem_read;
    logic        bmem_write;
    logic [31:0] bmem_addr;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic        bmem_rvalid;
    logic [63:0] bmem_rdata;
    logic [31:0] bmem_raddr;
    logic        proto_err;

    bmem_burst_responder #(
        .DEPTH_LINES (256),
        .READ_LATENCY(LAT),
        .RQ_DEPTH    (RQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_addr  (bmem_addr),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rvalid(bmem_rvalid),
        .bmem_rdata (bmem_rdata),
        .bmem_raddr (bmem_raddr),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    logic exp_err;

    logic [255:0] model [256];
    logic [63:0]  exp_data [$];
    logic [31:0]  exp_addr [$];
    int           beat_cyc [$];
    logic [63:0]  ed;
    logic [31:0]  ea;

    // Scoreboard side: every beat pops one expected entry
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bmem_rvalid) begin
                beat_cyc.push_back(cyc);
                if (exp_data.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: cycle %0d rdata %h raddr %h, no beat expected",
                             cyc, bmem_rdata, bmem_raddr);
                end else begin
                    ed = exp_data.pop_front();
                    ea = exp_addr.pop_front();
                    if (bmem_rdata !== ed || bmem_raddr !== ea) begin
                        n_fail++;
                        $display("FAIL beat_data: cycle %0d got %h @%h, expected %h @%h",
                                 cyc, bmem_rdata, bmem_raddr, ed, ea);
                    end
                end
            end else if (bmem_rdata !== 64'h0) begin
                n_fail++;
                $display("FAIL rdata_idle: cycle %0d got %h, expected 0", cyc, bmem_rdata);
            end
        end
    end

    function automatic logic [255:0] pat(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        return {{8{b3}}, {8{b2}}, {8{b1}}, {8{b0}}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        step();
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [255:0] line);
        for (int k = 0; k < 4; k++) begin
            bmem_write = 1'b1;
            bmem_addr  = (k == 0) ? a : 32'hdead_beef;
            bmem_wdata = line[64*k +: 64];
            step();
        end
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        model[a[12:5]] = line;
    endtask

    task automatic issue_read(input logic [31:0] a, input bit accepted);
        logic [255:0] l;
        bmem_read = 1'b1;
        bmem_addr = a;
        if (accepted) begin
            l = model[a[12:5]];
            for (int k = 0; k < 4; k++) begin
                exp_data.push_back(l[64*k +: 64]);
                exp_addr.push_back({a[31:5], 5'b0});
            end
        end
        step();
        bmem_read = 1'b0;
        bmem_addr = '0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_data.size() != 0; i++) step();
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks += 4;
        if (bmem_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bmem_rvalid);
        end
        if (bmem_rdata !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 0", bmem_rdata);
        end
        if (bmem_raddr !== 32'h0) begin
            n_fail++; $display("FAIL reset_raddr: got %h expected 0", bmem_raddr);
        end
        if (proto_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_proto_err: got %b expected 0", proto_err);
        end
        rst = 1'b0;
        step();
        mon_en = 1'b1;
        n_checks++;
        if (bmem_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", bmem_ready);
        end
    endtask

    task automatic test_write_read();
        beat_cyc.delete();
        drive_write(32'h100, pat(8'h11, 8'h22, 8'h33, 8'h44));
        issue_read(32'h100, 1'b1);
        wait_drain(30);
        n_checks += 2;
        if (exp_data.size() != 0) begin
            n_fail++; $display("FAIL wr_rd_drain: %0d beats missing, expected 0", exp_data.size());
        end
        if (beat_cyc.size() != 4) begin
            n_fail++; $display("FAIL wr_rd_beats: got %0d beats expected 4", beat_cyc.size());
        end
    endtask

    task automatic test_latency();
        int a;
        drive_write(32'h180, pat(8'ha1, 8'hb2, 8'hc3, 8'hd4));
        idle(2);
        beat_cyc.delete();
        a = cyc;
        issue_read(32'h180, 1'b1);
        wait_drain(30);
        idle(4);
        n_checks++;
        if (beat_cyc.size() != 4) begin
            n_fail++; $display("FAIL lat_count: got %0d beats expected 4", beat_cyc.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (((k < beat_cyc.size()) ? beat_cyc[k] : -1) != a + LAT + k) begin
                n_fail++;
                $display("FAIL lat_beat%0d: got cycle %0d expected %0d", k,
                         (k < beat_cyc.size()) ? beat_cyc[k] : -1, a + LAT + k);
            end
        end
    endtask

    task automatic test_queue();
        int a;
        for (int i = 0; i < 5; i++)
            drive_write(32'h200 + 32'(i) * 32'h20,
                        pat(8'(8'h50 + i), 8'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i)));
        idle(2);
        beat_cyc.delete();
        a = cyc;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bmem_ready !== (i < 4)) begin
                n_fail++;
                $display("FAIL queue_ready%0d: got %b expected %b", i, bmem_ready, i < 4);
            end
            issue_read(32'h200 + 32'(i) * 32'h20, i < 4);
        end
        wait_drain(120);
        n_checks += 2;
        if (beat_cyc.size() != 16) begin
            n_fail++; $display("FAIL queue_count: got %0d beats expected 16", beat_cyc.size());
        end
        if (proto_err !== exp_err) begin
            n_fail++; $display("FAIL queue_proto_err: got %b expected %b", proto_err, exp_err);
        end
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (((4*g + k < beat_cyc.size()) ? beat_cyc[4*g + k] : -1)
                    != a + LAT + g * (3 + LAT) + k) begin
                    n_fail++;
                    $display("FAIL queue_timing g%0d b%0d: got cycle %0d expected %0d", g, k,
                             (4*g + k < beat_cyc.size()) ? beat_cyc[4*g + k] : -1,
                             a + LAT + g * (3 + LAT) + k);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_wrap();
        drive_write(32'h0000_0020, pat(8'hc0, 8'hc1, 8'hc2, 8'hc3));
        idle(2);
        issue_read(32'h0000_2020, 1'b1);
        wait_drain(30);
        n_checks++;
        if (exp_data.size() != 0) begin
            n_fail++; $display("FAIL wrap_drain: %0d beats missing, expected 0", exp_data.size());
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        drive_write(32'h40, pat(8'h0a, 8'h0b, 8'h0c, 8'h0d));
        idle(2);
        bmem_write = 1'b1;
        bmem_addr  = 32'h40;
        bmem_wdata = 64'hffff_0000_ffff_0000;
        step();
        bmem_wdata = 64'h1234_5678_9abc_def0;
        step();
        bmem_write = 1'b0;
        bmem_wdata = '0;
        step();
        n_checks += 2;
        if (proto_err !== exp_err) begin
            n_fail++; $display("FAIL abort_proto_err: got %b expected %b", proto_err, exp_err);
        end
        if (bmem_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_ready: got %b expected 1", bmem_ready);
        end
        issue_read(32'h40, 1'b1);
        wait_drain(30);
        n_checks++;
        if (exp_data.size() != 0) begin
            n_fail++; $display("FAIL abort_drain: %0d beats missing, expected 0", exp_data.size());
        end
    endtask

    task automatic test_conflict();
        logic [255:0] l;
        int n0;
        do_reset();
        l = pat(8'he0, 8'he1, 8'he2, 8'he3);
        beat_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            bmem_read  = (k < 2);
            bmem_write = 1'b1;
            bmem_addr  = (k == 0) ? 32'h60 : 32'h80;
            bmem_wdata = l[64*k +: 64];
            step();
        end
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        model[8'h03] = l;
        n_checks++;
        if (proto_err !== exp_err) begin
            n_fail++; $display("FAIL conflict_proto_err: got %b expected %b", proto_err, exp_err);
        end
        idle(LAT + 8);
        n0 = beat_cyc.size();
        n_checks++;
        if (n0 != 0) begin
            n_fail++; $display("FAIL conflict_dropped: got %0d beats expected 0", n0);
        end
        issue_read(32'h60, 1'b1);
        wait_drain(30);
        n_checks++;
        if (exp_data.size() != 0) begin
            n_fail++; $display("FAIL conflict_drain: %0d beats missing, expected 0", exp_data.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        int a;
        int b;
        drive_write(32'h300, pat(8'h31, 8'h32, 8'h33, 8'h34));
        drive_write(32'h320, pat(8'h41, 8'h42, 8'h43, 8'h44));
        idle(2);
        beat_cyc.delete();
        a = cyc;
        issue_read(32'h300, 1'b1);
        issue_read(32'h320, 1'b1);
        for (int i = 0; i < 20 && cyc < a + LAT + 2; i++) step();
        rst = 1'b1;
        step();
        n_checks++;
        if (bmem_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_rvalid: got %b expected 0", bmem_rvalid);
        end
        rst = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        idle(LAT + 12);
        n_checks += 2;
        if (beat_cyc.size() != 3) begin
            n_fail++; $display("FAIL rstmid_beats: got %0d beats expected 3", beat_cyc.size());
        end
        if (bmem_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready: got %b expected 1", bmem_ready);
        end
        b = cyc;
        issue_read(32'h320, 1'b1);
        wait_drain(30);
        n_checks += 2;
        if (beat_cyc.size() != 7) begin
            n_fail++; $display("FAIL rstmid_after: got %0d beats expected 7", beat_cyc.size());
        end
        if (((beat_cyc.size() > 3) ? beat_cyc[3] : -1) != b + LAT) begin
            n_fail++;
            $display("FAIL rstmid_latency: got cycle %0d expected %0d",
                     (beat_cyc.size() > 3) ? beat_cyc[3] : -1, b + LAT);
        end
    endtask

    initial begin
`ifdef BMEM_RESP_PROTOCOL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst        = 1'b1;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        test_reset();
        test_write_read();
        test_latency();
        test_queue();
        test_wrap();
        test_proto_err();
        test_conflict();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
